// File: rtl/id_inst_queue.sv
// Decoupling {pc, inst} queue between IF and ID with a load-use interlock
// on the head instruction and a saturating count of interlock stall cycles.
module id_inst_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LOAD_LAT = 2,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_inst,
    output logic             in_ready,
    output logic             id_valid,
    output logic [31:0]      id_pc,
    output logic [31:0]      id_inst,
    input  logic             id_ready,
    input  logic             flush,
    output logic             stallreq,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CQ_W  = $clog2(DEPTH + 1);

    logic [31:0]     pc_mem   [DEPTH];
    logic [31:0]     inst_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CQ_W-1:0]  count;

    logic [LOAD_LAT-1:0] sb_valid;
    logic [4:0]          sb_reg [LOAD_LAT];

    logic       empty;
    logic       push;
    logic       pop;
    logic       hazard;
    logic [5:0] opcode;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       uses_rs;
    logic       uses_rt;
    logic       is_load;

    // Queue status and handshakes; a flush swallows any same-cycle push.
    always_comb begin
        empty    = (count == '0);
        in_ready = (count != CQ_W'(DEPTH));
        push     = in_valid & in_ready & ~flush;
        pop      = id_valid & id_ready;
    end

    // First-word-fall-through head view, zeroed while empty.
    always_comb begin
        id_pc   = '0;
        id_inst = '0;
        if (!empty) begin
            id_pc   = pc_mem[rd_ptr];
            id_inst = inst_mem[rd_ptr];
        end
    end

    // Register-use decode of the head instruction.
    always_comb begin
        opcode  = id_inst[31:26];
        rs      = id_inst[25:21];
        rt      = id_inst[20:16];
        uses_rs = !((opcode == 6'b000010) || (opcode == 6'b000011) || (opcode == 6'b001111));
        uses_rt = (opcode == 6'b000000) || (opcode == 6'b000100) || (opcode == 6'b000101)
                  || (opcode[5:3] == 3'b101);
        is_load = (opcode[5:3] == 3'b100);
    end

    // Hazard against any pending load destination; $0 never interlocks.
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < int'(LOAD_LAT); k++) begin
            if (sb_valid[k] && (sb_reg[k] != 5'd0) &&
                ((uses_rs && (sb_reg[k] == rs)) || (uses_rt && (sb_reg[k] == rt)))) begin
                hazard = 1'b1;
            end
        end
        hazard   = hazard & ~empty;
        id_valid = ~empty & ~hazard;
        stallreq = hazard;
    end

    // Entry storage needs no reset: the head view is gated by count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]   <= in_pc;
            inst_mem[wr_ptr] <= in_inst;
        end
    end

    // Pointers and occupancy; flush empties the queue but lets a pop issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CQ_W'(1);
                2'b01:   count <= count - CQ_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Load scoreboard shift chain; issued loads survive a flush.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb_valid <= '0;
            for (int k = 0; k < int'(LOAD_LAT); k++) sb_reg[k] <= 5'd0;
        end else begin
            for (int k = int'(LOAD_LAT) - 1; k > 0; k--) begin
                sb_valid[k] <= sb_valid[k-1];
                sb_reg[k]   <= sb_reg[k-1];
            end
            if (pop && is_load && (rt != 5'd0)) begin
                sb_valid[0] <= 1'b1;
                sb_reg[0]   <= rt;
            end else begin
                sb_valid[0] <= 1'b0;
                sb_reg[0]   <= 5'd0;
            end
        end
    end

    // Saturating interlock stall counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stallreq && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_id_inst_queue.sv
// Directed table-driven bench for id_inst_queue (DEPTH=4, LOAD_LAT=2),
// plus a hand-written asynchronous reset sequence in the middle of a stall.
module tb_id_inst_queue;

    localparam logic [31:0] LW8   = 32'h8D28_0000; // lw   $8,0($9)
    localparam logic [31:0] ADDU  = 32'h0102_5021; // addu $10,$8,$2
    localparam logic [31:0] ORI   = 32'h3483_0001; // ori  $3,$4,1
    localparam logic [31:0] LW0   = 32'h8D20_0000; // lw   $0,0($9)
    localparam logic [31:0] ADDU5 = 32'h0000_2821; // addu $5,$0,$0

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_pc = '0;
    logic [31:0] in_inst = '0;
    logic        in_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        id_ready = 1'b0;
    logic        flush = 1'b0;
    logic        stallreq;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    id_inst_queue #(.DEPTH(4), .LOAD_LAT(2), .CNT_W(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_pc     (in_pc),
        .in_inst   (in_inst),
        .in_ready  (in_ready),
        .id_valid  (id_valid),
        .id_pc     (id_pc),
        .id_inst   (id_inst),
        .id_ready  (id_ready),
        .flush     (flush),
        .stallreq  (stallreq),
        .stall_cnt (stall_cnt)
    );

    typedef struct packed {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] inst;
        logic        rdy;
        logic        fl;
        logic        e_rdy;
        logic        e_val;
        logic        e_st;
        logic [31:0] e_pc;
        logic [31:0] e_inst;
        logic [15:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [31:0] inst,
                                input logic rdy, input logic fl, input logic er, input logic ev,
                                input logic es, input logic [31:0] ep, input logic [31:0] ei,
                                input logic [15:0] ec);
        vec_t v;
        v.iv = iv; v.pc = pc; v.inst = inst; v.rdy = rdy; v.fl = fl;
        v.e_rdy = er; v.e_val = ev; v.e_st = es; v.e_pc = ep; v.e_inst = ei; v.e_cnt = ec;
        return v;
    endfunction

    // Filler word: ori $0,$0,pc[15:0] never reads a nonzero register.
    function automatic logic [31:0] fi(input logic [31:0] pc);
        return 32'h3400_0000 | {16'h0, pc[15:0]};
    endfunction

    task automatic check(input string name, input logic er, input logic ev, input logic es,
                         input logic [31:0] ep, input logic [31:0] ei, input logic [15:0] ec);
        n_tests++;
        if (in_ready !== er || id_valid !== ev || stallreq !== es || id_pc !== ep ||
            id_inst !== ei || stall_cnt !== ec) begin
            n_fail++;
            $display("FAIL %s: got rdy=%0b val=%0b st=%0b pc=%h inst=%h cnt=%0d, expected rdy=%0b val=%0b st=%0b pc=%h inst=%h cnt=%0d",
                     name, in_ready, id_valid, stallreq, id_pc, id_inst, stall_cnt,
                     er, ev, es, ep, ei, ec);
        end
    endtask

    initial begin
        logic [31:0] p;
        logic [31:0] h;

        // Fill: push four entries with decode stalled, then a rejected fifth.
        for (int k = 0; k < 5; k++) begin
            p = 32'hBFC0_0000 + 32'(4 * k);
            if (k == 0) vecs.push_back(mk(1'b1, p, fi(p), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0));
            else        vecs.push_back(mk(1'b1, p, fi(p), 1'b0, 1'b0, (k < 4), 1'b1, 1'b0,
                                          32'hBFC0_0000, fi(32'hBFC0_0000), 16'd0));
        end
        // Streaming with wrap: IF holds 0x..10 until accepted.
        for (int k = 0; k < 8; k++) begin
            p = (k == 0) ? 32'hBFC0_0010 : 32'hBFC0_0010 + 32'(4 * (k - 1));
            h = 32'hBFC0_0000 + 32'(4 * k);
            vecs.push_back(mk(1'b1, p, fi(p), 1'b1, 1'b0, (k != 0), 1'b1, 1'b0, h, fi(h), 16'd0));
        end
        for (int k = 0; k < 3; k++) begin
            h = 32'hBFC0_0020 + 32'(4 * k);
            vecs.push_back(mk(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, h, fi(h), 16'd0));
        end
        // Load-use interlock: two stall cycles.
        vecs.push_back(mk(1'b1, 32'h200, LW8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 16'd0));
        vecs.push_back(mk(1'b1, 32'h204, ADDU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, LW8,   16'd0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h200, LW8,   16'd0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, ADDU,  16'd0));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h204, ADDU,  16'd1));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h204, ADDU,  16'd2));
        // Independent instruction behind a load; load to $0.
        vecs.push_back(mk(1'b1, 32'h300, LW8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 16'd2));
        vecs.push_back(mk(1'b1, 32'h304, ORI,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, LW8,   16'd2));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h300, LW8,   16'd2));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h304, ORI,   16'd2));
        vecs.push_back(mk(1'b1, 32'h400, LW0,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 16'd2));
        vecs.push_back(mk(1'b1, 32'h404, ADDU5,1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, LW0,   16'd2));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h400, LW0,   16'd2));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h404, ADDU5, 16'd2));
        // Flush with 3 queued, a pushed 0x100 dropped, and a load popped in the flush cycle.
        vecs.push_back(mk(1'b1, 32'h500, LW8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 16'd2));
        vecs.push_back(mk(1'b1, 32'h504, ADDU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500, LW8,   16'd2));
        vecs.push_back(mk(1'b1, 32'h508, fi(32'h508), 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h500, LW8, 16'd2));
        vecs.push_back(mk(1'b1, 32'h100, fi(32'h100), 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 32'h500, LW8, 16'd2));
        vecs.push_back(mk(1'b1, 32'h600, ADDU, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 16'd2));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h600, ADDU,  16'd2));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h600, ADDU,  16'd3));
        // Build up to a stall with two entries queued and stall_cnt at 5.
        vecs.push_back(mk(1'b1, 32'h700, LW8,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0,   32'h0, 16'd3));
        vecs.push_back(mk(1'b1, 32'h704, ADDU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, LW8,   16'd3));
        vecs.push_back(mk(1'b1, 32'h708, LW8,  1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, LW8,   16'd3));
        vecs.push_back(mk(1'b1, 32'h70C, ADDU, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h700, LW8,   16'd3));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h700, LW8,   16'd3));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h704, ADDU,  16'd3));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 32'h704, ADDU,  16'd4));
        vecs.push_back(mk(1'b0, 32'h0,   32'h0,1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h704, ADDU,  16'd5));
        vecs.push_back(mk(1'b1, 32'h710, fi(32'h710), 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h708, LW8, 16'd5));

        repeat (2) @(negedge clk);
        #1 check("reset", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            @(negedge clk);
            in_valid = vecs[i].iv;
            in_pc    = vecs[i].pc;
            in_inst  = vecs[i].inst;
            id_ready = vecs[i].rdy;
            flush    = vecs[i].fl;
            #1 check($sformatf("vec%0d", i), vecs[i].e_rdy, vecs[i].e_val, vecs[i].e_st,
                     vecs[i].e_pc, vecs[i].e_inst, vecs[i].e_cnt);
        end

        // Async reset in the middle of a stall, released before the next edge.
        @(negedge clk);
        in_valid = 1'b0;
        id_ready = 1'b1;
        flush    = 1'b0;
        #1 check("pre_rst_stall", 1'b1, 1'b0, 1'b1, 32'h70C, ADDU, 16'd5);
        #1 rst = 1'b1;
        #1 check("async_rst", 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 16'd0);
        #1 rst = 1'b0;
        in_valid = 1'b1;
        in_pc    = 32'h800;
        in_inst  = ADDU;
        id_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        #1 check("post_rst_no_stall", 1'b1, 1'b1, 1'b0, 32'h800, ADDU, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
